// File: rtl/mips_mem_pkg.sv
// Shared types for the IF/MEM SRAM port arbiter: FSM states, port owner and write-enable constants.
package mips_mem_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// Combinational winner select between IF and MEM for the shared SRAM port.
// ARB_RR_EN selects round-robin; otherwise MEM has fixed priority over IF.
module arb_pick
  import mips_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  owner_t last,
  input  logic   allow,
  output logic   gnt_if,
  output logic   gnt_mem
);

`ifdef ARB_RR_EN
  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (allow) begin
      if (if_req && mem_req) begin
        if (last == OWN_IF) gnt_mem = 1'b1;
        else                gnt_if  = 1'b1;
      end else begin
        gnt_if  = if_req;
        gnt_mem = mem_req;
      end
    end
  end
`else
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (allow) begin
      gnt_mem = mem_req;
      gnt_if  = if_req && !mem_req;
    end
  end

  logic unused_last;
  assign unused_last = (last == OWN_MEM);
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between IF and MEM, tracks the outstanding read and routes its data.
// Build option: define ARB_RR_EN for round-robin arbitration (default is fixed MEM priority).
module sram_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic [AW-1:0] mem_addr,
  input  logic [3:0]    mem_wen,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_wen,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  owner_t           owner;
  logic             drop;
  owner_t           last;

  logic allow;
  logic done;
  logic mem_wr;
  logic rd_gnt;

  // Reset gating keeps every output low in the reset cycle.
  assign allow  = rst && ((state == IDLE) || (cnt == '0));
  assign done   = rst && (state == BUSY) && (cnt == '0);
  assign mem_wr = (mem_wen != WEN_NONE);
  assign rd_gnt = if_gnt || (mem_gnt && !mem_wr);

  arb_pick u_pick (
    .if_req  (if_req),
    .mem_req (mem_req),
    .last    (last),
    .allow   (allow),
    .gnt_if  (if_gnt),
    .gnt_mem (mem_gnt)
  );

  always_comb begin
    sram_en    = if_gnt || mem_gnt;
    sram_addr  = '0;
    sram_wen   = WEN_NONE;
    sram_wdata = '0;
    if (mem_gnt) begin
      sram_addr  = mem_addr;
      sram_wen   = mem_wen;
      sram_wdata = mem_wdata;
    end else if (if_gnt) begin
      sram_addr  = if_addr;
    end
  end

  // A flush in the completion cycle suppresses the stale fetch as well as a latched drop.
  assign if_rvalid  = done && (owner == OWN_IF) && !drop && !if_flush;
  assign mem_rvalid = done && (owner == OWN_MEM);
  assign if_rdata   = rst ? sram_rdata : '0;
  assign mem_rdata  = rst ? sram_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWN_IF;
      drop  <= 1'b0;
    end else if (rd_gnt) begin
      state <= BUSY;
      cnt   <= CNT_W'(RD_LAT - 1);
      owner <= mem_gnt ? OWN_MEM : OWN_IF;
      drop  <= 1'b0;
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
        if (if_flush && (owner == OWN_IF)) drop <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst)                   last <= OWN_IF;
    else if (if_gnt || mem_gnt) last <= mem_gnt ? OWN_MEM : OWN_IF;
  end
`else
  assign last = OWN_IF;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Table-driven bench for sram_port_arbiter; three instances cover RD_LAT = 1, 2 and 3.
module tb_sram_port_arbiter;

  localparam int N_DUT = 3;

  logic        clk;
  logic        rst;
  logic        if_req, if_flush, mem_req;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [3:0]  mem_wen;

  logic [N_DUT-1:0] o_igt, o_mgt, o_iv, o_mv, o_en;
  logic [31:0]      o_ird [N_DUT];
  logic [31:0]      o_mrd [N_DUT];
  logic [31:0]      o_addr [N_DUT];
  logic [31:0]      o_wdata [N_DUT];
  logic [3:0]       o_wen [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    sram_port_arbiter #(.RD_LAT(g + 1), .AW(32), .DW(32)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_flush   (if_flush),
      .if_gnt     (o_igt[g]),
      .if_rvalid  (o_iv[g]),
      .if_rdata   (o_ird[g]),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (o_mgt[g]),
      .mem_rvalid (o_mv[g]),
      .mem_rdata  (o_mrd[g]),
      .sram_en    (o_en[g]),
      .sram_addr  (o_addr[g]),
      .sram_wen   (o_wen[g]),
      .sram_wdata (o_wdata[g]),
      .sram_rdata (sram_rdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        ifl, mreq;
    logic [31:0] maddr;
    logic [3:0]  mwen;
    logic [31:0] mwdata, rdata;
    logic        igt, mgt, iv, mv;
    logic [31:0] eaddr;
    logic [3:0]  ewen;
    logic [31:0] ewdata, erd;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void mk(int sel, logic r, logic ireq, logic [31:0] iaddr, logic ifl,
                             logic mreq, logic [31:0] maddr, logic [3:0] mwen,
                             logic [31:0] mwdata, logic [31:0] rdata,
                             logic igt, logic mgt, logic iv, logic mv,
                             logic [31:0] eaddr, logic [3:0] ewen, logic [31:0] ewdata,
                             logic [31:0] erd);
    vec_t v;
    v = '{sel, r, ireq, iaddr, ifl, mreq, maddr, mwen, mwdata, rdata,
          igt, mgt, iv, mv, eaddr, ewen, ewdata, erd};
    tbl.push_back(v);
  endfunction

  // Reset cycle: every output is expected low.
  function automatic void rst_row(int sel, logic [31:0] rdata);
    mk(sel, 0, 1, 'h123, 1, 1, 'h456, 0, 0, rdata, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void idle_row(int sel, logic [31:0] rdata);
    mk(sel, 1, 0, 0, 0, 0, 0, 0, 0, rdata, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string nm, logic [72:0] act, logic [72:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    // 1: single IF read, RD_LAT=1
    rst_row(0, 'hDEADBEEF);
    mk(0, 1, 1, 'h100, 0, 0, 0, 0, 0, 'hDEADBEEF, 1, 0, 0, 0, 'h100, 0, 0, 0);
    mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 'hDEADBEEF);
    idle_row(0, 'hDEADBEEF);
    // 2: simultaneous requests, MEM first, RD_LAT=2
    rst_row(1, 0);
    mk(1, 1, 1, 'h300, 0, 1, 'h200, 0, 0, 0, 0, 1, 0, 0, 'h200, 0, 0, 0);
    mk(1, 1, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mk(1, 1, 1, 'h300, 0, 0, 0, 0, 0, 'h11112222, 1, 0, 0, 1, 'h300, 0, 0, 'h11112222);
    idle_row(1, 0);
    mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 'h33334444, 0, 0, 1, 0, 0, 0, 0, 'h33334444);
    idle_row(1, 0);
    // 3: MEM write, then IF read; a write during the read completion returns the port to IDLE
    rst_row(0, 0);
    mk(0, 1, 0, 0, 0, 1, 'h40, 4'b0011, 'h0000ABCD, 0, 0, 1, 0, 0, 'h40, 4'b0011, 'h0000ABCD, 0);
    mk(0, 1, 1, 'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h104, 0, 0, 0);
    mk(0, 1, 0, 0, 0, 1, 'h44, 4'b1111, 'hFFFF0000, 'h5, 0, 1, 1, 0, 'h44, 4'b1111, 'hFFFF0000, 'h5);
    idle_row(0, 'h5);
    // 4: flush of an outstanding fetch, RD_LAT=3; flush alongside a new grant leaves it intact
    rst_row(2, 0);
    mk(2, 1, 1, 'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h500, 0, 0, 0);
    mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mk(2, 1, 1, 'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mk(2, 1, 1, 'h600, 1, 0, 0, 0, 0, 'hAA, 1, 0, 0, 0, 'h600, 0, 0, 0);
    idle_row(2, 0);
    idle_row(2, 0);
    mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 'hBB, 0, 0, 1, 0, 0, 0, 0, 'hBB);
    // 4b: flush only in the completion cycle
    mk(2, 1, 1, 'h700, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h700, 0, 0, 0);
    idle_row(2, 0);
    idle_row(2, 0);
    mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 'hCC, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_row(2, 0);
    // 5: reset right after a MEM read grant, RD_LAT=2
    rst_row(1, 0);
    mk(1, 1, 0, 0, 0, 1, 'h800, 0, 0, 0, 0, 1, 0, 0, 'h800, 0, 0, 0);
    rst_row(1, 'h77);
    idle_row(1, 'h77);
    idle_row(1, 'h77);
    mk(1, 1, 1, 'h900, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h900, 0, 0, 0);
    idle_row(1, 0);
    mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 'h12345678, 0, 0, 1, 0, 0, 0, 0, 'h12345678);
    // 6: both requesters held continuously, RD_LAT=1
    rst_row(0, 0);
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 0, 1, 0, 0, 'hA00, 0, 0, 0);
`ifdef ARB_RR_EN
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 1, 0, 0, 1, 'hB00, 0, 0, 'h99);
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 0, 1, 1, 0, 'hA00, 0, 0, 'h99);
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 1, 0, 0, 1, 'hB00, 0, 0, 'h99);
    mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 'h99, 0, 0, 1, 0, 0, 0, 0, 'h99);
`else
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 0, 1, 0, 1, 'hA00, 0, 0, 'h99);
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 0, 1, 0, 1, 'hA00, 0, 0, 'h99);
    mk(0, 1, 1, 'hB00, 0, 1, 'hA00, 0, 0, 'h99, 0, 1, 0, 1, 'hA00, 0, 0, 'h99);
    mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 'h99, 0, 0, 0, 1, 0, 0, 0, 'h99);
`endif
    idle_row(0, 0);

    rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wen = '0; mem_wdata = '0; sram_rdata = '0;

    foreach (tbl[i]) begin
      vec_t t;
      int   s;
      logic [72:0] act, exp;
      t = tbl[i];
      s = t.sel;
      @(negedge clk);
      rst = t.rst; if_req = t.ireq; if_addr = t.iaddr; if_flush = t.ifl;
      mem_req = t.mreq; mem_addr = t.maddr; mem_wen = t.mwen; mem_wdata = t.mwdata;
      sram_rdata = t.rdata;
      #1;
      act = {o_igt[s], o_mgt[s], o_iv[s], o_mv[s], o_en[s], o_addr[s], o_wen[s], o_wdata[s]};
      exp = {t.igt, t.mgt, t.iv, t.mv, t.igt | t.mgt, t.eaddr, t.ewen, t.ewdata};
      chk($sformatf("row%0d_lat%0d_ctl", i, s + 1), act, exp);
      if (t.iv || !t.rst) chk($sformatf("row%0d_if_rdata", i), 73'(o_ird[s]), 73'(t.erd));
      if (t.mv || !t.rst) chk($sformatf("row%0d_mem_rdata", i), 73'(o_mrd[s]), 73'(t.erd));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
